// File: rtl/dp_arbiter.sv
// Round-robin arbiter sharing one draw/memory datapath between NUM_REQ sequencers.
// Requests are latched, issued one at a time with a 2-cycle start, and results return to the owner.
module dp_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_BITS = 2,
   parameter int INSTR_W = 64,
   parameter int RES_W   = 32
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic [NUM_REQ-1:0]         req_start,
   input  logic [NUM_REQ*INSTR_W-1:0] req_instr,
   output logic [NUM_REQ-1:0]         req_finished,
   output logic [NUM_REQ*RES_W-1:0]   req_result,
   output logic                       dp_start,
   output logic [INSTR_W-1:0]         dp_instr,
   input  logic                       dp_finished,
   input  logic [RES_W-1:0]           dp_result,
   output logic                       busy,
   output logic [ID_BITS-1:0]         grant_id
);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT} state_e;

   state_e                   state_q, state_d;
   logic [NUM_REQ-1:0]       pending_q;
   logic [NUM_REQ-1:0]       req_finished_q;
   logic [NUM_REQ*RES_W-1:0] req_result_q;
   logic [INSTR_W-1:0]       instr_buf_q [NUM_REQ];
   logic [INSTR_W-1:0]       dp_instr_q;
   logic                     dp_start_q;
   logic [ID_BITS-1:0]       owner_q;
   logic [ID_BITS-1:0]       rr_ptr_q;

   logic [NUM_REQ-1:0]       capture;
   logic [NUM_REQ-1:0]       grant_mask;
   logic [NUM_REQ-1:0]       done_mask;
   logic [ID_BITS-1:0]       sel;
   logic [ID_BITS-1:0]       rr_next;
   logic                     sel_vld;
   logic                     grant;
   logic                     complete;
   logic                     in_flight;

   assign in_flight = (state_q != IDLE);

   // First pending index at or after rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      int idx;
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      sel_vld = 1'b0;
      sel     = '0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!sel_vld && pending_q[idx]) begin
            sel_vld = 1'b1;
            sel     = ID_BITS'(idx);
         end
      end
   end

   // A start is taken only from an idle requester that is not the one currently being served.
   always_comb begin
      capture = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         capture[i] = req_start[i] && !pending_q[i] && !(in_flight && owner_q == ID_BITS'(i));
      end
   end

   always_comb begin
      state_d  = state_q;
      grant    = 1'b0;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (sel_vld) begin
               grant   = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = HOLD;
         HOLD:  state_d = WAIT;
         WAIT: begin
            if (dp_finished) begin
               complete = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign grant_mask = grant    ? (NUM_REQ'(1) << sel)     : '0;
   assign done_mask  = complete ? (NUM_REQ'(1) << owner_q) : '0;
   assign rr_next    = (owner_q == ID_BITS'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pending_q      <= '0;
         req_finished_q <= '1;
         req_result_q   <= '0;
         dp_instr_q     <= '0;
         dp_start_q     <= 1'b0;
         owner_q        <= '0;
         rr_ptr_q       <= '0;
      end else begin
         dp_start_q     <= (state_d == ISSUE) || (state_d == HOLD);
         pending_q      <= (pending_q | capture) & ~grant_mask;
         req_finished_q <= (req_finished_q & ~capture) | done_mask;
         if (grant) begin
            owner_q    <= sel;
            dp_instr_q <= instr_buf_q[sel];
         end
         if (complete) begin
            req_result_q[owner_q*RES_W +: RES_W] <= dp_result;
            rr_ptr_q                             <= rr_next;
         end
      end
   end

   // NOTE: the instruction buffer has no reset; a slot is only read after its pending bit was set by a write.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (capture[i]) instr_buf_q[i] <= req_instr[i*INSTR_W +: INSTR_W];
      end
   end

   assign req_finished = req_finished_q;
   assign req_result   = req_result_q;
   assign dp_start     = dp_start_q;
   assign dp_instr     = dp_instr_q;
   assign busy         = in_flight;
   assign grant_id     = owner_q;

endmodule

// File: tb/tb_dp_arbiter.sv
// Directed bench for dp_arbiter: vector table of grant orders plus multi-cycle corner sequences.
module tb_dp_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_BITS = 2;
   localparam int INSTR_W = 64;
   localparam int RES_W   = 32;

   logic                       clock;
   logic                       resetn;
   logic [NUM_REQ-1:0]         req_start;
   logic [NUM_REQ*INSTR_W-1:0] req_instr;
   logic [NUM_REQ-1:0]         req_finished;
   logic [NUM_REQ*RES_W-1:0]   req_result;
   logic                       dp_start;
   logic [INSTR_W-1:0]         dp_instr;
   logic                       dp_finished;
   logic [RES_W-1:0]           dp_result;
   logic                       busy;
   logic [ID_BITS-1:0]         grant_id;

   dp_arbiter #(
      .NUM_REQ(NUM_REQ), .ID_BITS(ID_BITS), .INSTR_W(INSTR_W), .RES_W(RES_W)
   ) dut (
      .clock(clock), .resetn(resetn),
      .req_start(req_start), .req_instr(req_instr),
      .req_finished(req_finished), .req_result(req_result),
      .dp_start(dp_start), .dp_instr(dp_instr),
      .dp_finished(dp_finished), .dp_result(dp_result),
      .busy(busy), .grant_id(grant_id)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   int dp_lat = 2;

   logic [ID_BITS-1:0] log_gid [$];
   logic [INSTR_W-1:0] log_instr [$];

   typedef struct packed {
      logic [3:0] mask;
      logic [2:0] n;
      logic [7:0] order;
   } vec_t;

   vec_t vecs [7];

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out waiting for the DUT", name);
   endtask

   function automatic logic [63:0] instr_of(int r, int i);
      return 64'h5A00_0000_0000_0000 | (64'(r) << 8) | 64'(i);
   endfunction

   function automatic logic [31:0] res_of(logic [63:0] x);
      return x[31:0] + 32'h778;
   endfunction

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic wait_idle(string name);
      int n = 0;
      while (!(req_finished == 4'hF && !busy) && n < 500) begin
         tick();
         n++;
      end
      if (n >= 500) timeout_fail(name);
   endtask

   task automatic do_reset();
      req_start = '0;
      resetn    = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic clear_log();
      log_gid.delete();
      log_instr.delete();
   endtask

   // Datapath model: drops finished on a new start, raises it dp_lat cycles later with a result.
   initial begin
      logic [63:0] cur;
      logic        prev;
      int          cnt;
      dp_finished = 1'b1;
      dp_result   = '0;
      prev        = 1'b0;
      cnt         = 0;
      cur         = '0;
      forever begin
         @(posedge clock);
         #1;
         if (dp_start && !prev) begin
            dp_finished = 1'b0;
            dp_result   = 32'hDEAD_BEEF;
            cnt         = dp_lat;
            cur         = dp_instr;
         end else if (!dp_finished && cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               dp_finished = 1'b1;
               dp_result   = res_of(cur);
            end
         end
         prev = dp_start;
      end
   end

   // Issue monitor: logs each op and checks the start pulse width.
   initial begin
      logic mprev;
      int   len;
      mprev = 1'b0;
      len   = 0;
      forever begin
         @(posedge clock);
         #2;
         if (!resetn) begin
            mprev = 1'b0;
            len   = 0;
         end else begin
            if (dp_start && !mprev) begin
               log_gid.push_back(grant_id);
               log_instr.push_back(dp_instr);
            end
            if (dp_start) len++;
            else if (mprev) begin
               check("dp_start_len", 128'(len), 128'd2);
               len = 0;
            end
            mprev = dp_start;
         end
      end
   end

   initial begin
      logic [ID_BITS-1:0] exp_g;
      int cnt [NUM_REQ];
      int waited;
      int budget;

      vecs[0] = '{mask: 4'b1011, n: 3'd3, order: {2'd0, 2'd3, 2'd1, 2'd0}};
      vecs[1] = '{mask: 4'b0100, n: 3'd1, order: {6'd0, 2'd2}};
      vecs[2] = '{mask: 4'b0011, n: 3'd2, order: {4'd0, 2'd1, 2'd0}};
      vecs[3] = '{mask: 4'b1111, n: 3'd4, order: {2'd1, 2'd0, 2'd3, 2'd2}};
      vecs[4] = '{mask: 4'b1001, n: 3'd2, order: {4'd0, 2'd0, 2'd3}};
      vecs[5] = '{mask: 4'b0110, n: 3'd2, order: {4'd0, 2'd2, 2'd1}};
      vecs[6] = '{mask: 4'b0001, n: 3'd1, order: {6'd0, 2'd0}};

      req_start = '0;
      req_instr = '0;
      resetn    = 1'b1;
      tick();
      do_reset();

      check("rst_finished", 128'(req_finished), 128'hF);
      check("rst_result",   128'(req_result),   128'h0);
      check("rst_dp_start", 128'(dp_start),     128'h0);
      check("rst_dp_instr", 128'(dp_instr),     128'h0);
      check("rst_busy",     128'(busy),         128'h0);
      check("rst_grant_id", 128'(grant_id),     128'h0);

      // Vector table: rr_ptr carries from one record to the next.
      for (int r = 0; r < 7; r++) begin
         clear_log();
         for (int i = 0; i < NUM_REQ; i++)
            if (vecs[r].mask[i]) req_instr[i*INSTR_W +: INSTR_W] = instr_of(r, i);
         req_start = vecs[r].mask;
         tick();
         tick();
         req_start = '0;
         tick();
         wait_idle("tbl_idle");
         check("tbl_nops", 128'(log_gid.size()), 128'(vecs[r].n));
         for (int k = 0; k < int'(vecs[r].n) && k < log_gid.size(); k++) begin
            exp_g = vecs[r].order[2*k +: 2];
            check("tbl_grant", 128'(log_gid[k]), 128'(exp_g));
            check("tbl_instr", 128'(log_instr[k]), 128'(instr_of(r, int'(exp_g))));
         end
         for (int i = 0; i < NUM_REQ; i++)
            if (vecs[r].mask[i])
               check("tbl_result", 128'(req_result[i*RES_W +: RES_W]), 128'(res_of(instr_of(r, i))));
         check("tbl_finished", 128'(req_finished), 128'hF);
      end

      // Fairness: every requester re-requests as soon as it sees finished, 3 times each.
      do_reset();
      clear_log();
      for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
      budget = 0;
      while (!(log_gid.size() == 12 && req_finished == 4'hF && !busy && req_start == '0) && budget < 3000) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_finished[i] && cnt[i] < 3 && !req_start[i]) begin
               req_instr[i*INSTR_W +: INSTR_W] = instr_of(10 + cnt[i], i);
               req_start[i] = 1'b1;
               cnt[i]++;
            end else begin
               req_start[i] = 1'b0;
            end
         end
         tick();
         budget++;
      end
      if (budget >= 3000) timeout_fail("fair_idle");
      check("fair_nops", 128'(log_gid.size()), 128'd12);
      for (int k = 0; k < 12 && k < log_gid.size(); k++) begin
         check("fair_grant", 128'(log_gid[k]), 128'(k % 4));
         check("fair_instr", 128'(log_instr[k]), 128'(instr_of(10 + k / 4, k % 4)));
      end

      // Ignored restart: requester 2 re-pulses start with a new instruction while pending.
      clear_log();
      req_instr[0*INSTR_W +: INSTR_W] = 64'h0000_0000_0000_0A00;
      req_instr[2*INSTR_W +: INSTR_W] = 64'h0000_0000_0000_0A22;
      req_start = 4'b0101;
      tick();
      req_start = '0;
      tick();
      req_instr[2*INSTR_W +: INSTR_W] = 64'h0000_0000_0000_0B22;
      req_start = 4'b0100;
      tick();
      req_start = '0;
      check("rs_pending_fin", 128'(req_finished[2]), 128'h0);
      wait_idle("rs_idle");
      repeat (10) tick();
      check("rs_nops", 128'(log_gid.size()), 128'd2);
      if (log_gid.size() >= 2) begin
         check("rs_grant", 128'(log_gid[1]), 128'd2);
         check("rs_instr", 128'(log_instr[1]), 128'h0A22);
      end
      check("rs_result", 128'(req_result[2*RES_W +: RES_W]), 128'(res_of(64'h0A22)));

      // Start on the completion edge of the same owner is taken one edge later.
      clear_log();
      req_instr[0*INSTR_W +: INSTR_W] = 64'h0000_0000_0000_0C00;
      req_start = 4'b0001;
      tick();
      req_start = '0;
      budget = 0;
      while (!dp_start && budget < 50) begin tick(); budget++; end
      while (dp_start && budget < 50) begin tick(); budget++; end
      req_instr[0*INSTR_W +: INSTR_W] = 64'h0000_0000_0000_0D00;
      req_start = 4'b0001;
      while (!req_finished[0] && budget < 100) begin tick(); budget++; end
      if (budget >= 100) timeout_fail("sim_complete");
      tick();
      check("sim_refall", 128'(req_finished[0]), 128'h0);
      req_start = '0;
      tick();
      wait_idle("sim_idle");
      check("sim_nops", 128'(log_gid.size()), 128'd2);
      if (log_gid.size() >= 2) begin
         check("sim_instr0", 128'(log_instr[0]), 128'h0C00);
         check("sim_grant1", 128'(log_gid[1]), 128'd0);
         check("sim_instr1", 128'(log_instr[1]), 128'h0D00);
      end

      // Slow datapath: finished held low for 20 WAIT cycles.
      dp_lat = 22;
      req_instr[0*INSTR_W +: INSTR_W] = 64'h0000_0000_0000_0E00;
      req_start = 4'b0001;
      tick();
      req_start = '0;
      budget = 0;
      while (!dp_start && budget < 50) begin tick(); budget++; end
      while (dp_start && budget < 50) begin tick(); budget++; end
      if (budget >= 50) timeout_fail("slow_issue");
      waited = 0;
      while (!dp_finished && waited < 100) begin
         check("slow_dp_start", 128'(dp_start), 128'h0);
         check("slow_busy", 128'(busy), 128'h1);
         check("slow_fin", 128'(req_finished[0]), 128'h0);
         waited++;
         tick();
      end
      check("slow_wait_cycles", 128'(waited), 128'd20);
      check("slow_fin_pre", 128'(req_finished[0]), 128'h0);
      tick();
      check("slow_fin_post", 128'(req_finished[0]), 128'h1);
      check("slow_busy_post", 128'(busy), 128'h0);
      check("slow_result", 128'(req_result[0*RES_W +: RES_W]), 128'(res_of(64'h0E00)));
      dp_lat = 2;

      // Single request from requester 1 right after reset.
      do_reset();
      req_instr[1*INSTR_W +: INSTR_W] = 64'h0000_0000_0000_0ABC;
      req_start = 4'b0010;
      tick();
      check("single_fin_low", 128'(req_finished), 128'b1101);
      check("single_busy_pre", 128'(busy), 128'h0);
      tick();
      req_start = '0;
      check("single_dp_start1", 128'(dp_start), 128'h1);
      check("single_dp_instr", 128'(dp_instr), 128'h0ABC);
      check("single_grant", 128'(grant_id), 128'h1);
      check("single_busy", 128'(busy), 128'h1);
      tick();
      check("single_dp_start2", 128'(dp_start), 128'h1);
      tick();
      check("single_dp_start3", 128'(dp_start), 128'h0);
      wait_idle("single_idle");
      check("single_result", 128'(req_result[1*RES_W +: RES_W]), 128'h1234);
      check("single_others", 128'(req_result & ~(128'hFFFF_FFFF << 32)), 128'h0);
      check("single_finished", 128'(req_finished), 128'hF);

      // Async reset mid-HOLD, then round-robin restarts from 0.
      req_instr[3*INSTR_W +: INSTR_W] = 64'h0000_0000_0000_0F33;
      req_start = 4'b1000;
      tick();
      req_start = '0;
      tick();
      tick();
      check("ar_hold", 128'(dp_start), 128'h1);
      resetn = 1'b0;
      #1;
      check("ar_finished", 128'(req_finished), 128'hF);
      check("ar_result",   128'(req_result),   128'h0);
      check("ar_dp_start", 128'(dp_start),     128'h0);
      check("ar_dp_instr", 128'(dp_instr),     128'h0);
      check("ar_busy",     128'(busy),         128'h0);
      check("ar_grant_id", 128'(grant_id),     128'h0);
      tick();
      tick();
      resetn = 1'b1;
      tick();
      clear_log();
      req_instr[1*INSTR_W +: INSTR_W] = 64'h0000_0000_0000_0111;
      req_instr[3*INSTR_W +: INSTR_W] = 64'h0000_0000_0000_0333;
      req_start = 4'b1010;
      tick();
      tick();
      req_start = '0;
      tick();
      wait_idle("ar_idle");
      check("ar_nops", 128'(log_gid.size()), 128'd2);
      if (log_gid.size() >= 2) begin
         check("ar_grant0", 128'(log_gid[0]), 128'd1);
         check("ar_grant1", 128'(log_gid[1]), 128'd3);
         check("ar_instr1", 128'(log_instr[1]), 128'h0333);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation exceeded its time limit");
      $fatal(1);
   end

endmodule
